// File: rtl/maxnet_iterator.sv
// Four-neuron MAXNET winner-take-all iterator: repeated mutual inhibition of
// unsigned Q16.16 activations until at most one neuron stays nonzero.
module maxnet_iterator #(
    parameter int unsigned WIDTH    = 32,
    parameter logic [15:0] EPS      = 16'h2000,
    parameter int unsigned MAX_ITER = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] x3,
    input  logic [WIDTH-1:0] x4,
    output logic [WIDTH-1:0] a1,
    output logic [WIDTH-1:0] a2,
    output logic [WIDTH-1:0] a3,
    output logic [WIDTH-1:0] a4,
    output logic [3:0]       nz,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       winner,
    output logic             none,
    output logic             timeout,
    output logic [7:0]       iter
);

    localparam int unsigned SW = WIDTH + 2;
    localparam int unsigned PW = WIDTH + 18;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] act     [4];
    logic [WIDTH-1:0] act_nxt [4];
    logic [SW-1:0]    others  [4];
    logic [SW-1:0]    sub     [4];
    logic [SW-1:0]    total;
    logic [3:0]       nz_nxt;
    logic [2:0]       pop;
    logic [1:0]       sole_idx;
    logic [1:0]       max_idx;
    logic [WIDTH-1:0] best;

    assign a1 = act[0];
    assign a2 = act[1];
    assign a3 = act[2];
    assign a4 = act[3];

    // Inhibition step, survivor count and winner candidates from current state
    always_comb begin
        total    = '0;
        pop      = '0;
        sole_idx = '0;
        max_idx  = '0;
        best     = act[0];
        nz_nxt   = '0;
        for (int i = 0; i < 4; i++) begin
            total = total + SW'(act[i]);
            pop   = pop + 3'(nz[i]);
        end
        for (int i = 3; i >= 0; i--) begin
            if (nz[i]) sole_idx = 2'(i);
        end
        for (int i = 1; i < 4; i++) begin
            if (act[i] > best) begin
                best    = act[i];
                max_idx = 2'(i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            others[i]  = total - SW'(act[i]);
            sub[i]     = SW'((PW'(EPS) * PW'(others[i])) >> 16);
            // Saturate at zero: compare at full width before subtracting
            act_nxt[i] = (sub[i] >= SW'(act[i])) ? '0 : act[i] - sub[i][WIDTH-1:0];
            nz_nxt[i]  = (act_nxt[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            for (int i = 0; i < 4; i++) act[i] <= '0;
            nz        <= '0;
            iter      <= '0;
            winner    <= '0;
            none      <= 1'b0;
            timeout   <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        act[0]   <= x1;
                        act[1]   <= x2;
                        act[2]   <= x3;
                        act[3]   <= x4;
                        nz       <= {x4 != '0, x3 != '0, x2 != '0, x1 != '0};
                        iter     <= '0;
                        none     <= 1'b0;
                        timeout  <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (pop <= 3'd1) begin
                        winner    <= sole_idx;
                        none      <= (pop == 3'd0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (iter == 8'(MAX_ITER)) begin
                        winner    <= max_idx;
                        timeout   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        act  <= act_nxt;
                        nz   <= nz_nxt;
                        iter <= iter + 8'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/maxnet_iterator.md
MAXNET_ITERATOR -- requirements
Module: maxnet_iterator

Interface
REQ-001 SHALL have parameter WIDTH, default 32, activation width (unsigned Q16.16).
REQ-002 SHALL have parameter EPS, default 16'h2000, inhibition weight epsilon (unsigned Q0.16, 0.125).
REQ-003 SHALL have parameter MAX_ITER, default 64, iteration limit (1..255).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  load request.
REQ-007 SHALL have port in_ready  output  1  block idle, will accept a load.
REQ-008 SHALL have ports x1, x2, x3, x4  input  WIDTH  initial activations.
REQ-009 SHALL have ports a1, a2, a3, a4  output  WIDTH  current activations (registered).
REQ-010 SHALL have port nz  output  4  per-neuron nonzero flags; bit i-1 = (ai != 0).
REQ-011 SHALL have port out_valid  output  1  result ready.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port winner  output  2  index of the sole nonzero neuron (0 = a1).
REQ-014 SHALL have port none  output  1  all activations zero at completion.
REQ-015 SHALL have port timeout  output  1  MAX_ITER reached with more than one nonzero neuron.
REQ-016 SHALL have port iter  output  8  iterations completed for the current job.

Function
REQ-017 SHALL implement states IDLE, RUN and DONE.
REQ-018 IDLE SHALL drive in_ready=1; in_valid=1 SHALL latch x1..x4 into a1..a4, clear iter, none and timeout, and enter RUN on the next edge.
REQ-019 RUN SHALL, each cycle, test nz of the current a values before updating: popcount(nz)<=1 SHALL go to DONE without updating a.
REQ-020 Otherwise, if iter==MAX_ITER, RUN SHALL set timeout=1 and go to DONE without updating a.
REQ-021 Otherwise every ai SHALL update simultaneously to max(0, ai - ((EPS * Si) >> 16)), where Si = sum of the other three activations.
REQ-022 Si SHALL be computed at WIDTH+2 bits and the product at WIDTH+18 bits, with no overflow.
REQ-023 Each update SHALL saturate at zero: the subtrahend SHALL be compared against ai at full width, with no wrap.
REQ-024 Each update SHALL increment iter by 1; the update takes exactly one cycle.
REQ-025 On entering DONE, winner SHALL equal the index of the set nz bit; with popcount 0, winner=0 and none=1.
REQ-026 On timeout, winner SHALL be the lowest index with the largest ai.
REQ-027 DONE SHALL hold out_valid=1 with a, nz, winner, none, timeout and iter stable until out_ready=1, then return to IDLE on that edge.
REQ-028 in_valid SHALL be ignored outside IDLE, and in_ready SHALL be 0 in RUN and DONE.
REQ-029 Equal maxima SHALL decay symmetrically; reaching all-zero SHALL end with none=1.
REQ-030 A load with popcount(nz)<=1 SHALL spend exactly one cycle in RUN, with iter=0.
REQ-031 a1..a4 and nz SHALL remain visible in IDLE and hold the last job's values.

Reset
REQ-032 rst_n=0 SHALL asynchronously force IDLE, a1..a4=0, iter=0, winner=0, none=0, timeout=0 and out_valid=0, in any state including mid-RUN.
REQ-033 After rst_n deasserts, in_ready SHALL be 1 on the first clock edge, and a partially completed job SHALL be discarded.

Verification
REQ-034 Load x=(4.0, 3.0, 2.0, 1.0), EPS=0.125 -> a4 reaches 0 first, then a3, then a2; ends winner=0, none=0, timeout=0; each iteration matches a bit-exact reference model.
REQ-035 Load x=(0, 0, 5.0, 0) -> DONE after 1 RUN cycle, winner=2, iter=0, a3=5.0 unchanged.
REQ-036 Load x=(2.0, 2.0, 0, 0) -> a1 and a2 stay equal each cycle, the job never reaches a single winner within the limit, and with MAX_ITER=4 the result is timeout=1, winner=0, iter=4.
REQ-037 Load x=(0, 0, 0, 0) -> DONE in 1 cycle, none=1, winner=0.
REQ-038 In DONE, hold out_ready=0 for 5 cycles while pulsing in_valid -> outputs stable, no reload; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-039 Assert rst_n=0 mid-RUN between clock edges -> out_valid=0 and a=0 immediately; after release, a new load runs correctly.
